// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the spi_master_arbiter block.
// Holds the FSM state type, the post-retire dvld blanking length and a
// helper that sizes the grant index.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETIRE
  } arb_state_e;

  // Cycles during which IDLE ignores spi_dvld after an acknowledge, covering
  // the core's dvld deassert latency.
  localparam int IGNORE_CYCLES = 1;

  // ceil(log2(n)), never below 1, for the grant index width.
  function automatic int idx_width(input int n);
    for (int w = 1; w < 31; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Requester and spi_master-core signal bundle for spi_master_arbiter.
// The master modport is the arbiter's view; slave is the requesters plus
// the attached core.
interface spi_master_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int NBITS   = 24,
  parameter int NCSBITS = 3
);

  // Requester side
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*NBITS-1:0]   req_din;
  logic [NREQ*NCSBITS-1:0] req_cs;
  logic [NREQ*NCSBITS-1:0] req_cs_idle;
  logic [NREQ-1:0]         rsp_valid;
  logic [NBITS-1:0]        rsp_dout;
  logic                    rsp_err;

  // spi_master core side
  logic                    spi_trigger;
  logic                    spi_ack;
  logic [NBITS-1:0]        spi_din;
  logic [NCSBITS-1:0]      spi_cs_in;
  logic [NCSBITS-1:0]      spi_cs_in_idle;
  logic [NBITS-1:0]        spi_dout;
  logic                    spi_dvld;

  modport master (
    input  req_valid, req_din, req_cs, req_cs_idle, spi_dout, spi_dvld,
    output req_ready, rsp_valid, rsp_dout, rsp_err,
           spi_trigger, spi_ack, spi_din, spi_cs_in, spi_cs_in_idle
  );

  modport slave (
    output req_valid, req_din, req_cs, req_cs_idle, spi_dout, spi_dvld,
    input  req_ready, rsp_valid, rsp_dout, rsp_err,
           spi_trigger, spi_ack, spi_din, spi_cs_in, spi_cs_in_idle
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin selector: grants the first set req_valid bit
// searching upward from rr_ptr+1 (mod NREQ), as a one-hot vector plus index.
module spi_rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any
);

  // Rotating priority search starting just after the last winner.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!any && req_valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master core among NREQ requesters.
// Latches the winner's command, runs the core's trigger/dvld/ack handshake
// and returns the read word as a one-cycle tagged response.
// Optional watchdog: define SPI_MASTER_ARBITER_TIMEOUT_EN to abort a WAIT
// that sees no spi_dvld and answer with rsp_err=1.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int NBITS        = 24,
  parameter int NCSBITS      = 3,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_arbiter_if.master bus
);

  localparam int IDXW = idx_width(NREQ);

  arb_state_e      state;
  logic [IDXW-1:0] rr_ptr;
  logic [NREQ-1:0] gnt_oh;
  logic [1:0]      ign_cnt;

  logic [NREQ-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic            grant_any;

`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  // Fires on the WAIT cycle that would bring the counter to all-ones.
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
  logic [TIMEOUT_BITS-1:0] tmo_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = 1'(TIMEOUT_BITS);
`endif

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Transaction FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register updates from pre-edge values regardless of statement order.
      state              <= IDLE;
      rr_ptr             <= IDXW'(NREQ - 1);
      gnt_oh             <= '0;
      ign_cnt            <= '0;
      bus.req_ready      <= '0;
      bus.rsp_valid      <= '0;
      bus.rsp_dout       <= '0;
      bus.rsp_err        <= 1'b0;
      bus.spi_trigger    <= 1'b0;
      bus.spi_ack        <= 1'b0;
      bus.spi_din        <= '0;
      bus.spi_cs_in      <= '0;
      bus.spi_cs_in_idle <= '1;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
      tmo_cnt            <= '0;
`endif
    end else begin
      // Pulse outputs default low; the branches below raise them for one cycle.
      bus.req_ready   <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.spi_trigger <= 1'b0;
      bus.spi_ack     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (ign_cnt != 2'd0) ign_cnt <= ign_cnt - 2'd1;
          if (bus.spi_dvld && ign_cnt == 2'd0) begin
            // Stale result left over from an aborted transaction: drain it,
            // then blank dvld while the core drops it.
            bus.spi_ack <= 1'b1;
            ign_cnt     <= 2'(IGNORE_CYCLES);
          end else if (grant_any) begin
            bus.req_ready      <= grant;
            gnt_oh             <= grant;
            rr_ptr             <= grant_idx;
            bus.spi_din        <= bus.req_din[grant_idx*NBITS +: NBITS];
            bus.spi_cs_in      <= bus.req_cs[grant_idx*NCSBITS +: NCSBITS];
            bus.spi_cs_in_idle <= bus.req_cs_idle[grant_idx*NCSBITS +: NCSBITS];
            state              <= ISSUE;
          end
        end

        ISSUE: begin
          bus.spi_trigger <= 1'b1;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
          tmo_cnt         <= '0;
`endif
          state           <= WAIT;
        end

        WAIT: begin
          if (bus.spi_dvld) begin
            // Response and acknowledge are both visible during RETIRE.
            bus.rsp_dout  <= bus.spi_dout;
            bus.rsp_valid <= gnt_oh;
            bus.spi_ack   <= 1'b1;
            state         <= RETIRE;
          end
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            bus.rsp_dout  <= '0;
            bus.rsp_valid <= gnt_oh;
            bus.rsp_err   <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RETIRE: begin
          ign_cnt <= 2'(IGNORE_CYCLES);
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed self-checking bench for spi_master_arbiter with a small
// behavioural spi_master core model (fixed-latency dvld, cleared by ack).
module tb_spi_master_arbiter;

  localparam int NREQ = 4;
  localparam int NB   = 24;
  localparam int NCS  = 3;
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
  localparam int TMO_BITS = 4;
  localparam int LONG_LAT = 10;
  localparam int RST_AT   = 5;
`else
  localparam int TMO_BITS = 16;
  localparam int LONG_LAT = 50;
  localparam int RST_AT   = 20;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NREQ(NREQ), .NBITS(NB), .NCSBITS(NCS)) bus ();

  spi_master_arbiter #(
    .NREQ         (NREQ),
    .NBITS        (NB),
    .NCSBITS      (NCS),
    .TIMEOUT_BITS (TMO_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: dvld rises core_lat cycles after trigger, drops on ack.
  int          core_lat = 0;
  logic [23:0] core_word = '0;
  bit          stale_hold = 1'b0;
  bit          model_clr = 1'b1;
  int          cnt;

  always @(posedge clk) begin
    if (model_clr) begin
      bus.spi_dvld <= 1'b0;
      bus.spi_dout <= '0;
      cnt          <= 0;
    end else begin
      if (bus.spi_ack) bus.spi_dvld <= 1'b0;
      if (stale_hold) begin
        bus.spi_dvld <= 1'b1;
        bus.spi_dout <= 24'hDEAD00;
      end
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) begin
          bus.spi_dvld <= 1'b1;
          bus.spi_dout <= core_word;
        end
      end
      if (bus.spi_trigger && core_lat > 0) cnt <= core_lat;
    end
  end

  function automatic logic [23:0] din_of(input int i);
    return 24'hA5A5A5 ^ 24'(i * 24'h111111);
  endfunction

  function automatic logic [2:0] cs_of(input int i);
    return 3'b110 ^ 3'(i);
  endfunction

  task automatic wait_ready(input logic [3:0] exp, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(exp));
  endtask

  task automatic wait_rsp(input logic [3:0] exp, input logic [23:0] word, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) break;
    end
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(exp));
    check({tag, "_rsp_dout"}, 32'(bus.rsp_dout), 32'(word));
    check({tag, "_ack"}, 32'(bus.spi_ack), 32'd1);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  // One full transaction for requester g; optionally drops its valid on accept.
  task automatic run_txn(input int g, input logic [23:0] word, input int lat,
                         input bit drop, input string tag);
    core_lat  = lat;
    core_word = word;
    wait_ready(4'(1 << g), tag);
    if (drop) bus.req_valid[g] = 1'b0;
    @(negedge clk);
    check({tag, "_trig"}, 32'(bus.spi_trigger), 32'd1);
    check({tag, "_din"}, 32'(bus.spi_din), 32'(din_of(g)));
    check({tag, "_cs"}, 32'(bus.spi_cs_in), 32'(cs_of(g)));
    @(negedge clk);
    check({tag, "_trig_off"}, 32'(bus.spi_trigger), 32'd0);
    wait_rsp(4'(1 << g), word, tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_trig"}, 32'(bus.spi_trigger), 32'd0);
    check({tag, "_ack"}, 32'(bus.spi_ack), 32'd0);
    check({tag, "_din"}, 32'(bus.spi_din), 32'd0);
    check({tag, "_cs"}, 32'(bus.spi_cs_in), 32'd0);
    check({tag, "_cs_idle"}, 32'(bus.spi_cs_in_idle), 32'h7);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts ack pulses and responses over a window.
  task automatic observe(input int cycles, output int acks, output int rsps);
    acks = 0;
    rsps = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.spi_ack) begin
        acks++;
        stale_hold = 1'b0;
      end
      if (bus.rsp_valid != '0) rsps++;
    end
  endtask

  initial begin
    int acks;
    int rsps;
    int errs;
    int n;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_din[i*NB +: NB]       = din_of(i);
      bus.req_cs[i*NCS +: NCS]      = cs_of(i);
      bus.req_cs_idle[i*NCS +: NCS] = 3'b111;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    model_clr = 1'b0;
    rst_n     = 1'b1;

    // Single request from requester 0.
    bus.req_valid[0] = 1'b1;
    run_txn(0, 24'h123456, LONG_LAT, 1'b1, "single");
    repeat (3) @(negedge clk);
    check("single_cs_hold", 32'(bus.spi_cs_in), 32'h6);
    check("single_idle_hold", 32'(bus.spi_cs_in_idle), 32'h7);

    // Four requesters held valid: fair rotation 0,1,2,3,0,1,2,3.
    pulse_reset();
    bus.req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      run_txn(k % 4, 24'h100000 + 24'(k), 5, 1'b0, $sformatf("rr%0d", k));
    end
    bus.req_valid = '0;
    repeat (4) @(negedge clk);

    // Stale dvld present out of reset: one drain ack, no response.
    @(negedge clk);
    rst_n      = 1'b0;
    stale_hold = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    observe(10, acks, rsps);
    check("stale_acks", 32'(acks), 32'd1);
    check("stale_rsps", 32'(rsps), 32'd0);
    bus.req_valid[2] = 1'b1;
    run_txn(2, 24'h0BEEF2, 8, 1'b1, "post_stale");

    // Reset in the middle of WAIT: late dvld drained without a response.
    bus.req_valid[1] = 1'b1;
    core_lat  = LONG_LAT;
    core_word = 24'h5A5A5A;
    wait_ready(4'b0010, "midrst");
    bus.req_valid[1] = 1'b0;
    repeat (RST_AT) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst_rst");
    @(negedge clk);
    rst_n = 1'b1;
    observe(LONG_LAT + 20, acks, rsps);
    check("midrst_acks", 32'(acks), 32'd1);
    check("midrst_rsps", 32'(rsps), 32'd0);
    bus.req_valid[3] = 1'b1;
    run_txn(3, 24'h777777, 10, 1'b1, "post_midrst");

    // Core that never answers.
    core_lat = 0;
    bus.req_valid[0] = 1'b1;
    wait_ready(4'b0001, "hang");
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("hang_trig", 32'(bus.spi_trigger), 32'd1);
`ifdef SPI_MASTER_ARBITER_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      n = i;
      if (bus.rsp_valid != '0) break;
    end
    check("tmo_cycles", 32'(n), 32'd15);
    check("tmo_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("tmo_err", 32'(bus.rsp_err), 32'd1);
    check("tmo_dout", 32'(bus.rsp_dout), 32'd0);
    check("tmo_ack", 32'(bus.spi_ack), 32'd0);
`else
    rsps = 0;
    errs = 0;
    n    = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) rsps++;
      if (bus.rsp_err) errs++;
    end
    check("hang_rsps", 32'(rsps), 32'd0);
    check("hang_err", 32'(errs), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master core between NREQ independent requesters, for example several peripheral controllers each driving its own chip select.
- Arbitrates round-robin, latches the winner's command and runs the core's trigger/dvld/ack handshake.
- Returns the read-back word to the winning requester as a one-cycle tagged response.
- Sits between the requesters and the spi_master trigger/ack port, in the same clock domain as the core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 24, SPI word width; must match the attached spi_master.
- NCSBITS, 3, chip-select width; must match the attached spi_master.
- TIMEOUT_BITS, 16, width of the watchdog counter (used only with the optional feature).

Ports:
- clk  in  1  single clock; the spi_master core runs on the same clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester command valid; must be held until accepted.
- req_ready  out  NREQ  one-hot acceptance pulse.
- req_din  in  NREQ*NBITS  per-requester MOSI word; requester i occupies slice [i*NBITS +: NBITS].
- req_cs  in  NREQ*NCSBITS  per-requester active CS pattern.
- req_cs_idle  in  NREQ*NCSBITS  per-requester idle CS pattern.
- rsp_valid  out  NREQ  one-hot response pulse.
- rsp_dout  out  NBITS  MISO word, valid while rsp_valid is nonzero.
- rsp_err  out  1  timeout flag, qualified by rsp_valid.
- spi_trigger  out  1  start pulse to the core.
- spi_ack  out  1  acknowledge pulse to the core.
- spi_din  out  NBITS  word sent to the core.
- spi_cs_in  out  NCSBITS  active CS pattern sent to the core.
- spi_cs_in_idle  out  NCSBITS  idle CS pattern sent to the core.
- spi_dout  in  NBITS  read word from the core.
- spi_dvld  in  1  core data valid; held high until spi_ack.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=NREQ-1.
  - req_ready, rsp_valid, rsp_err, spi_trigger, spi_ack all 0.
  - spi_din, spi_cs_in and rsp_dout cleared to 0.
  - spi_cs_in_idle set to all-ones (all devices deselected).
- States: IDLE -> ISSUE -> WAIT -> RETIRE -> IDLE.
- IDLE:
  - If spi_dvld=1, this is a stale result (for example from a reset mid-transaction). Pulse spi_ack for one cycle, assert no response, grant nothing, stay in IDLE.
  - Otherwise, if any req_valid is set, grant the first set bit searching upward from rr_ptr+1 (mod NREQ).
  - On grant: pulse req_ready[g] for one cycle, latch req_din/req_cs/req_cs_idle slice g into the spi_* outputs, store g, set rr_ptr=g, go to ISSUE.
- ISSUE: spi_trigger=1 for exactly one cycle -> WAIT.
- WAIT: on spi_dvld=1, capture spi_dout into rsp_dout -> RETIRE.
- RETIRE:
  - In the same cycle: spi_ack=1, rsp_valid[g]=1, rsp_err=0.
  - Go to IDLE. IDLE ignores spi_dvld for 1 cycle after RETIRE, which covers the core's deassert latency.
- Latency: req_ready at cycle T, spi_trigger at T+1, rsp_valid one cycle after spi_dvld is sampled high.
- Response has no backpressure; the requester must take it in the pulse cycle.
- spi_cs_in and spi_cs_in_idle hold the last granted values between transactions.
- Simultaneous requests: round-robin fairness. With all NREQ requesting continuously, each is granted once every NREQ transactions.
- req_valid dropped before acceptance: allowed; that requester is not granted.
- A requester may reassert in the cycle after its rsp_valid.
- Reset mid-operation: the arbiter restarts in IDLE; the in-flight SPI word completes inside the core and is drained by the stale-dvld rule.

Optional Feature:
- Macro: SPI_MASTER_ARBITER_TIMEOUT_EN.
- Enabled:
  - A TIMEOUT_BITS-bit counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching all-ones without spi_dvld: rsp_valid[g]=1, rsp_err=1, rsp_dout=0, go to IDLE.
  - The core's late dvld is later drained by the IDLE stale rule.
- Disabled: no counter; WAIT waits indefinitely; rsp_err tied to 0.

Decomposition:
- Package spi_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RETIRE);
  - the localparam for the post-RETIRE ignore cycles (1);
  - a function computing clog2(NREQ) for the grant index.
- One natural sub-module: spi_rr_arbiter (combinational round-robin select from req_valid and rr_ptr, giving a one-hot grant plus its index).

Test Plan:
- Single request: req_valid=0001, din=0xA5A5A5, cs=3'b110, cs_idle=3'b111, core model returns 0x123456 after 50 cycles.
  Expect: req_ready=0001, spi_trigger one cycle later, rsp_valid=0001 with rsp_dout=0x123456, spi_ack coincident with rsp_valid.
- All four requesters held valid for 8 transactions.
  Expect: grant order 0,1,2,3,0,1,2,3; each rsp_valid bit matches its grant.
- Stale dvld: core model holds spi_dvld=1 out of reset with no request.
  Expect: one spi_ack pulse, no rsp_valid; then a normal request completes.
- Reset mid-WAIT: assert rst_n=0 for 2 cycles at cycle 20 of a 50-cycle transaction.
  Expect: outputs at reset values; late dvld drained with no response; next request served.
- With SPI_MASTER_ARBITER_TIMEOUT_EN and TIMEOUT_BITS=4, core never asserts dvld.
  Expect: rsp_valid with rsp_err=1 and rsp_dout=0 after 15 WAIT cycles.
- Without SPI_MASTER_ARBITER_TIMEOUT_EN, same stimulus.
  Expect: no response after 1000 cycles; rsp_err stays 0.
